// File: rtl/mobo_mem_responder_if.sv
// CPU <-> motherboard request/status bus: mobo_ctrl/addr/wr_data out of the CPU,
// mobo_stat/rd_data back from the memory responder.
interface mobo_mem_responder_if #(
    parameter int unsigned word_width = 32
) ();
    logic [word_width-1:0] mobo_ctrl;
    logic [word_width-1:0] addr;
    logic [word_width-1:0] wr_data;
    logic [word_width-1:0] mobo_stat;
    logic [word_width-1:0] rd_data;

    modport master (
        output mobo_ctrl, addr, wr_data,
        input  mobo_stat, rd_data
    );

    modport slave (
        input  mobo_ctrl, addr, wr_data,
        output mobo_stat, rd_data
    );
endinterface

// File: rtl/mobo_mem_responder.sv
// Motherboard memory responder: word-wide RAM behind a four-phase REQ/ACK handshake
// with WAIT_CYCLES wait states. Define MOBO_RESP_RANGE_CHK_EN to flag out-of-range addresses.
module mobo_mem_responder #(
    parameter int unsigned           word_width  = 32,
    parameter int unsigned           ADDR_BITS   = 8,
    parameter int unsigned           WAIT_CYCLES = 2,
    parameter logic [word_width-1:0] ERR_PATTERN = word_width'(32'hDEAD_BEEF)
) (
    input logic                 clk,
    input logic                 rst,
    mobo_mem_responder_if.slave bus_if
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [word_width-1:0]  wdata_q, wdata_d;
    logic                   oor_q, oor_d;
    logic [word_width-1:0]  stat_q, stat_d;
    logic [word_width-1:0]  rd_data_q, rd_data_d;
    logic [word_width-1:0]  mem_q [DEPTH];

    logic req_c;
    logic we_in_c;
    logic oor_c;
    logic access_c;
    logic mem_we_c;
    logic ack_c;
    logic busy_c;
    logic err_c;
    logic unused_bits;

    assign req_c   = bus_if.mobo_ctrl[0];
    assign we_in_c = bus_if.mobo_ctrl[1];

`ifdef MOBO_RESP_RANGE_CHK_EN
    assign oor_c       = |bus_if.addr[word_width-1:ADDR_BITS];
    assign unused_bits = ^bus_if.mobo_ctrl[word_width-1:2];
`else
    // Upper address bits are dropped so accesses alias modulo the RAM depth.
    assign oor_c       = 1'b0;
    assign unused_bits = ^{bus_if.mobo_ctrl[word_width-1:2],
                           bus_if.addr[word_width-1:ADDR_BITS]};
`endif

    // Next-state, access strobe and registered-output images.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        oor_d     = oor_q;
        rd_data_d = rd_data_q;
        access_c  = 1'b0;
        mem_we_c  = 1'b0;
        ack_c     = 1'b0;
        busy_c    = 1'b0;
        err_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    addr_d  = bus_if.addr[ADDR_BITS-1:0];
                    we_d    = we_in_c;
                    wdata_d = bus_if.wr_data;
                    oor_d   = oor_c;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A zero count means the wait budget is spent: access on this edge.
                if (cnt_q == '0) begin
                    access_c = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!req_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_we_c = access_c & we_q & ~oor_q;
        if (access_c && !we_q) begin
            rd_data_d = oor_q ? ERR_PATTERN : mem_q[addr_q];
        end

        ack_c  = (state_d == S_DONE);
        busy_c = (state_d != S_IDLE);
        err_c  = ack_c & oor_q;
        stat_d = word_width'({err_c, busy_c, ack_c});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            oor_q     <= 1'b0;
            stat_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            oor_q     <= oor_d;
            stat_q    <= stat_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus_if.mobo_stat = stat_q;
    assign bus_if.rd_data   = rd_data_q;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Randomized scoreboard bench for mobo_mem_responder: one instance with 2 wait states,
// one with 0, each checked against a word-array memory model.
module tb_mobo_mem_responder;

    localparam int unsigned WW     = 32;
    localparam int unsigned WAIT_A = 2;
    localparam int unsigned WAIT_B = 0;

    typedef struct {
        int          issue;
        bit          is_read;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_s  [2];
    logic        we_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] stat_s [2];
    logic [31:0] rdd_s  [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    logic [31:0] mdl [2][256];
    bit          vld [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mobo_mem_responder_if #(.word_width(WW)) bus_a ();
    mobo_mem_responder_if #(.word_width(WW)) bus_b ();

    assign bus_a.mobo_ctrl = {30'd0, we_s[0], req_s[0]};
    assign bus_a.addr      = addr_s[0];
    assign bus_a.wr_data   = wd_s[0];
    assign bus_b.mobo_ctrl = {30'd0, we_s[1], req_s[1]};
    assign bus_b.addr      = addr_s[1];
    assign bus_b.wr_data   = wd_s[1];
    assign stat_s[0] = bus_a.mobo_stat;
    assign rdd_s[0]  = bus_a.rd_data;
    assign stat_s[1] = bus_b.mobo_stat;
    assign rdd_s[1]  = bus_b.rd_data;

    mobo_mem_responder #(.word_width(WW), .ADDR_BITS(8), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .rst(rst), .bus_if(bus_a)
    );
    mobo_mem_responder #(.word_width(WW), .ADDR_BITS(8), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .rst(rst), .bus_if(bus_b)
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? int'(WAIT_A) : int'(WAIT_B);
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: RAM is a plain word array indexed by addr mod 256.
    task automatic push_expect(input int d, input bit we, input logic [31:0] a,
                               input logic [31:0] wd, input int issue);
        exp_t       e;
        logic [7:0] idx;
        bit         oor;
        idx = a[7:0];
        oor = 1'b0;
`ifdef MOBO_RESP_RANGE_CHK_EN
        oor = (a[31:8] != 24'd0);
`endif
        e.issue   = issue;
        e.is_read = !we;
        e.err     = oor;
        e.data    = 32'd0;
        e.chk_data = 1'b0;
        if (we) begin
            if (!oor) begin
                mdl[d][idx] = wd;
                vld[d][idx] = 1'b1;
            end
        end else if (oor) begin
            e.chk_data = 1'b1;
            e.data     = 32'hDEAD_BEEF;
        end else begin
            e.chk_data = vld[d][idx];
            e.data     = mdl[d][idx];
        end
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    // Monitor: every rising ACK is matched against the oldest expectation.
    bit   prev_ack [2];
    bit   ack_now;
    bit   have;
    exp_t me;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                prev_ack[d] = 1'b0;
            end else begin
                ack_now = stat_s[d][0];
                if (ack_now && !prev_ack[d]) begin
                    have = 1'b0;
                    if (d == 0 && exp_a.size() > 0) begin have = 1'b1; me = exp_a.pop_front(); end
                    if (d == 1 && exp_b.size() > 0) begin have = 1'b1; me = exp_b.pop_front(); end
                    if (!have) begin
                        check(1'b0, "unexpected_ack", stat_s[d], 32'd0);
                    end else begin
                        check(cyc == me.issue + wait_of(d) + 1, "ack_latency",
                              32'(cyc), 32'(me.issue + wait_of(d) + 1));
                        check(stat_s[d] == 32'({me.err, 2'b11}), "stat_done",
                              stat_s[d], 32'({me.err, 2'b11}));
                        if (me.is_read && me.chk_data) begin
                            check(rdd_s[d] == me.data, "rd_data", rdd_s[d], me.data);
                        end
                    end
                end
                prev_ack[d] = ack_now;
            end
        end
    end

    task automatic start_req(input int d, input bit we, input logic [31:0] a,
                             input logic [31:0] wd);
        req_s[d]  = 1'b1;
        we_s[d]   = we;
        addr_s[d] = a;
        wd_s[d]   = wd;
        push_expect(d, we, a, wd, cyc + 1);
    endtask

    // Called just after the sampling edge; closes the handshake and checks ACK shape.
    task automatic finish_req(input int d, input bit early, input int hold);
        bit got;
        if (early) begin
            @(negedge clk);
            req_s[d] = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (stat_s[d][0]) got = 1'b1;
        end
        if (!got) begin
            check(1'b0, "ack_timeout", stat_s[d], 32'd1);
            req_s[d] = 1'b0;
            return;
        end
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check(stat_s[d][0] == 1'b1, "ack_hold", stat_s[d], 32'd1);
            end
            req_s[d] = 1'b0;
        end
        @(negedge clk);
        check(stat_s[d] == 32'd0, "stat_idle_after_ack", stat_s[d], 32'd0);
    endtask

    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit early, input bit scramble, input int hold, input bit b2b);
        if (!b2b) @(negedge clk);
        start_req(d, we, a, wd);
        @(posedge clk);
        #1;
        if (scramble) begin
            addr_s[d] = a ^ 32'h0000_0003;
            wd_s[d]   = ~wd;
        end
        finish_req(d, early, hold);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 32'd0; wd_s[d] = 32'd0;
        end
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'd5; wd_s[0] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(stat_s[d] == 32'd0, "reset_stat", stat_s[d], 32'd0);
            check(rdd_s[d] == 32'd0, "reset_rd_data", rdd_s[d], 32'd0);
        end
        start_req(0, 1'b1, 32'd5, 32'h1234_5678);
        rst = 1'b1;
        @(posedge clk);
        #1;
        finish_req(0, 1'b0, 0);

        // Directed: read-back, zero-wait instance, latched-value use, early REQ drop, range.
        txn(0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1, 1'b1);
        txn(1, 1'b1, 32'd0, 32'h0000_00A5, 1'b0, 1'b0, 0, 1'b0);
        txn(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
        txn(0, 1'b1, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b1, 32'd3, 32'hCAFE_F00D, 1'b0, 1'b1, 0, 1'b0);
        txn(0, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b1, 32'd7, 32'h7777_0007, 1'b1, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        txn(1, 1'b1, 32'd7, 32'h0707_7070, 1'b1, 1'b0, 0, 1'b0);
        txn(1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b1, 32'h0000_0100, 32'h5555_AAAA, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 32'h0000_0100, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        txn(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);

        // Reset in WAIT must drop the pending write.
        txn(0, 1'b1, 32'd9, 32'h1111_2222, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'd9; wd_s[0] = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        check(stat_s[0] == 32'd2, "busy_in_wait", stat_s[0], 32'd2);
        rst = 1'b0;
        #1;
        check(stat_s[0] == 32'd0, "abort_stat", stat_s[0], 32'd0);
        req_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 90; n++) begin
            int          d;
            logic [31:0] a;
            d = (n % 3 == 2) ? 1 : 0;
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | (32'h100 << $urandom_range(0, 23));
            txn(d, 1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (5) @(negedge clk);
        check(exp_a.size() == 0, "scoreboard_drain_a", 32'(exp_a.size()), 32'd0);
        check(exp_b.size() == 0, "scoreboard_drain_b", 32'(exp_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
